// File: rtl/ssi_encoder_emulator.sv
// SSI slave that emulates an absolute encoder: snapshots a position word when
// chip-select falls and shifts it out MSB-first on the master's serial clock.
module ssi_encoder_emulator #(
    parameter int unsigned SSI_RES        = 10,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ssi_clk,
    input  logic               ncs,
    input  logic [SSI_RES-1:0] position,
    output logic               data_out,
    output logic               busy,
    output logic               frame_done,
    output logic               timeout
);

    localparam int unsigned IDX_W = $clog2(SSI_RES);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_SHIFT,
        ST_TAIL
    } state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] ncs_sync_q;
    logic                   sclk_prev_q;
    logic                   ncs_prev_q;
    logic                   sclk_rise_c;
    logic                   ncs_fall_c;
    logic                   ncs_rise_c;

    state_e                 state_q, state_d;
    logic [SSI_RES-1:0]     shreg_q, shreg_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   data_out_q, data_out_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   tmo_pulse_q, tmo_pulse_d;

    // ncs chain resets low so a chip-select already low at reset release is not seen as a fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            ncs_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], ssi_clk};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            ncs_prev_q  <= ncs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_rise_c = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign ncs_fall_c  = ~ncs_sync_q[SYNC_STAGES-1] & ncs_prev_q;
    assign ncs_rise_c  = ncs_sync_q[SYNC_STAGES-1] & ~ncs_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            idx_q       <= '0;
            tmo_q       <= '0;
            data_out_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tmo_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            data_out_q  <= data_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tmo_pulse_q <= tmo_pulse_d;
        end
    end

    // Priority inside a frame: ncs rise, then ssi_clk rise, then timeout
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q;
        data_out_d  = data_out_q;
        done_d      = 1'b0;
        tmo_pulse_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                data_out_d = 1'b1;
                if (ncs_fall_c) begin
                    shreg_d    = position;
                    data_out_d = position[SSI_RES-1];
                    idx_d      = '0;
                    tmo_d      = '0;
                    state_d    = ST_ARM;
                end
            end
            ST_ARM, ST_SHIFT: begin
                if (ncs_rise_c) begin
                    data_out_d = 1'b1;
                    state_d    = ST_IDLE;
                end else if (sclk_rise_c) begin
                    tmo_d = '0;
                    if (state_q == ST_ARM) begin
                        idx_d   = IDX_W'(SSI_RES - 1);
                        state_d = ST_SHIFT;
                    end else if (idx_q == '0) begin
                        data_out_d = 1'b0;
                        state_d    = ST_TAIL;
                    end else begin
                        idx_d      = idx_q - IDX_W'(1);
                        data_out_d = shreg_q[idx_q - IDX_W'(1)];
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    tmo_d       = '0;
                    tmo_pulse_d = 1'b1;
                    data_out_d  = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_TAIL: begin
                data_out_d = 1'b0;
                if (ncs_rise_c) begin
                    data_out_d = 1'b1;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                data_out_d = 1'b1;
                state_d    = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign data_out   = data_out_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign timeout    = tmo_pulse_q;

endmodule
